// File: rtl/mul_pipe_pkg.sv
// Shared types and helpers for the pipelined RV32M multiplier.
package mul_pipe_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_LEN   = 16;
  localparam int unsigned ROB_IDX_W = $clog2(ROB_LEN);
  localparam int unsigned RD_W      = 7;
  localparam int unsigned OPND_W    = XLEN + 1;
  // Wide enough for both packed extended operands and the full product.
  localparam int unsigned DATA_W    = 2 * OPND_W;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011
  } mul_op_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [RD_W-1:0]      rd;
    mul_op_t              op;
    logic [DATA_W-1:0]    data;
  } mul_uop_t;

  // Packs {op1, op2} as 33-bit extensions chosen by the op.
  function automatic logic [DATA_W-1:0] extend_operands(logic [2:0] funct3,
                                                        logic [XLEN-1:0] a,
                                                        logic [XLEN-1:0] b);
    logic sext1;
    logic sext2;
    sext1 = (funct3 != MULHU);
    sext2 = (funct3 == MUL) || (funct3 == MULH);
    return {sext1 & a[XLEN-1], a, sext2 & b[XLEN-1], b};
  endfunction

  // Signed 33x33 product of packed operands, truncated to DATA_W bits.
  function automatic logic [DATA_W-1:0] product(logic [DATA_W-1:0] ops);
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    x = {{OPND_W{ops[DATA_W-1]}}, ops[DATA_W-1:OPND_W]};
    y = {{OPND_W{ops[OPND_W-1]}}, ops[OPND_W-1:0]};
    return x * y;
  endfunction

  function automatic logic [XLEN-1:0] select_result(mul_op_t op, logic [DATA_W-1:0] prod);
    logic [XLEN-1:0] res;
    case (op)
      MUL:                 res = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: res = prod[2*XLEN-1:XLEN];
      default:             res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Issue, squash and writeback signals of the multiplier unit.
interface mul_pipe_if;
  import mul_pipe_pkg::*;

  logic [2:0]           funct3;
  logic [XLEN-1:0]      rs1_data;
  logic [XLEN-1:0]      rs2_data;
  logic                 mul_i_valid;
  logic [ROB_IDX_W-1:0] mul_i_rob_idx;
  logic [RD_W-1:0]      mul_i_rd;
  logic                 mul_o_ready;
  logic                 mispredict;
  logic [ROB_LEN-1:0]   flush_mask;
  logic                 mul_o_valid;
  logic [ROB_IDX_W-1:0] mul_o_rob_idx;
  logic [RD_W-1:0]      mul_o_rd;
  logic [XLEN-1:0]      mul_o_data;
  logic                 wb_ready;

  modport master (
    output funct3, rs1_data, rs2_data, mul_i_valid, mul_i_rob_idx, mul_i_rd,
    output mispredict, flush_mask, wb_ready,
    input  mul_o_ready, mul_o_valid, mul_o_rob_idx, mul_o_rd, mul_o_data
  );

  modport slave (
    input  funct3, rs1_data, rs2_data, mul_i_valid, mul_i_rob_idx, mul_i_rd,
    input  mispredict, flush_mask, wb_ready,
    output mul_o_ready, mul_o_valid, mul_o_rob_idx, mul_o_rd, mul_o_data
  );

endinterface

// File: rtl/mul_pipe_stage.sv
// One pipeline register: loads on advance, holds otherwise, squashes flagged ops.
module mul_pipe_stage
  import mul_pipe_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  input  logic               mispredict,
  input  logic [ROB_LEN-1:0] flush_mask,
  input  mul_uop_t           prev,
  output mul_uop_t           cur
);

  mul_uop_t uop_d;
  mul_uop_t uop_q;

  // Select incoming or held op, then kill it if its ROB entry is being squashed.
  always_comb begin
    uop_d = advance ? prev : uop_q;
    if (mispredict && flush_mask[uop_d.rob_idx]) begin
      uop_d.valid = 1'b0;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      uop_q <= '0;
    end else begin
      uop_q <= uop_d;
    end
  end

  assign cur = uop_q;

endmodule

// File: rtl/mul_pipe.sv
// Pipelined RV32M multiplier: fixed STAGES-cycle latency, back-pressure, selective squash.
module mul_pipe
  import mul_pipe_pkg::*;
#(
  parameter int unsigned STAGES = 3
) (
  input logic       clk,
  input logic       rst,
  mul_pipe_if.slave bus
);

  mul_uop_t stage_q [STAGES];
  mul_uop_t issue_uop;
  mul_uop_t last;
  logic     advance;
  logic     out_squash;

  // Stage 0 input: extended operands, or the full product when there is only one stage.
  always_comb begin
    issue_uop.valid   = bus.mul_i_valid;
    issue_uop.rob_idx = bus.mul_i_rob_idx;
    issue_uop.rd      = bus.mul_i_rd;
    issue_uop.op      = mul_op_t'(bus.funct3);
    issue_uop.data    = extend_operands(bus.funct3, bus.rs1_data, bus.rs2_data);
    if (STAGES == 1) begin
      issue_uop.data = product(issue_uop.data);
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    mul_uop_t prev;

    if (i == 0) begin : g_issue
      assign prev = issue_uop;
    end else if (i == 1) begin : g_mult
      // Stage 1 forms the product; later stages only retime it.
      always_comb begin
        prev      = stage_q[i-1];
        prev.data = product(stage_q[i-1].data);
      end
    end else begin : g_retime
      assign prev = stage_q[i-1];
    end

    mul_pipe_stage u_stage (
      .clk        (clk),
      .rst        (rst),
      .advance    (advance),
      .mispredict (bus.mispredict),
      .flush_mask (bus.flush_mask),
      .prev       (prev),
      .cur        (stage_q[i])
    );
  end

  assign last = stage_q[STAGES-1];

  // Output view; a squash of the output stage masks valid in the same cycle so it never retires.
  always_comb begin
    out_squash        = bus.mispredict && bus.flush_mask[last.rob_idx];
    bus.mul_o_valid   = last.valid && !out_squash;
    advance           = !bus.mul_o_valid || bus.wb_ready;
    bus.mul_o_ready   = advance;
    bus.mul_o_rob_idx = last.rob_idx;
    bus.mul_o_rd      = last.rd;
    bus.mul_o_data    = select_result(last.op, last.data);
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: scoreboard queue fed by the driver, drained by a monitor.
module tb_mul_pipe;
  import mul_pipe_pkg::*;

  localparam int unsigned STAGES = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_pipe_if bus ();

  mul_pipe #(.STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [ROB_IDX_W-1:0] rob;
    logic [RD_W-1:0]      rd;
    logic [XLEN-1:0]      data;
    int                   cyc;
  } exp_t;

  exp_t            exp_q[$];
  int              n_tests   = 0;
  int              n_fail    = 0;
  int              cyc       = 0;
  int              n_retired = 0;
  bit              lat_chk   = 1'b0;
  bit              last_fire = 1'b0;
  logic [XLEN-1:0] pend_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: full-width products from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_mul(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    sa = {{32{a[31]}}, a};
    ua = {32'h0, a};
    sb = {{32{b[31]}}, b};
    ub = {32'h0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- monitor ----------------
  bit                   stalled = 1'b0;
  logic [ROB_IDX_W-1:0] st_rob;
  logic [RD_W-1:0]      st_rd;
  logic [XLEN-1:0]      st_data;
  exp_t                 mon_e;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && bus.mul_o_valid) begin
        check("stall_rob", 64'(bus.mul_o_rob_idx), 64'(st_rob));
        check("stall_rd", 64'(bus.mul_o_rd), 64'(st_rd));
        check("stall_data", 64'(bus.mul_o_data), 64'(st_data));
      end
      check("ready_rule", 64'(bus.mul_o_ready), 64'(!bus.mul_o_valid || bus.wb_ready));
      if (bus.mul_o_valid && bus.wb_ready) begin
        n_retired++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got rob %0d data 0x%0h, expected no result",
                   bus.mul_o_rob_idx, bus.mul_o_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_rob", 64'(bus.mul_o_rob_idx), 64'(mon_e.rob));
          check("res_rd", 64'(bus.mul_o_rd), 64'(mon_e.rd));
          check("res_data", 64'(bus.mul_o_data), 64'(mon_e.data));
          if (lat_chk) check("latency", 64'(cyc - mon_e.cyc), 64'(STAGES));
        end
      end
      stalled = bus.mul_o_valid && !bus.wb_ready;
      st_rob  = bus.mul_o_rob_idx;
      st_rd   = bus.mul_o_rd;
      st_data = bus.mul_o_data;
    end
  end

  // ---------------- driver ----------------
  task automatic idle_inputs();
    bus.mul_i_valid = 1'b0;
    bus.mispredict  = 1'b0;
    bus.flush_mask  = '0;
  endtask

  task automatic issue(logic [2:0] f, logic [31:0] a, logic [31:0] b,
                       logic [ROB_IDX_W-1:0] rob, logic [RD_W-1:0] rd);
    bus.mul_i_valid   = 1'b1;
    bus.funct3        = f;
    bus.rs1_data      = a;
    bus.rs2_data      = b;
    bus.mul_i_rob_idx = rob;
    bus.mul_i_rd      = rd;
    pend_data         = ref_mul(f, a, b);
  endtask

  // Apply squash to the in-flight model, then at mid-cycle record an accepted issue.
  task automatic half();
    if (bus.mispredict) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (bus.flush_mask[exp_q[i].rob]) exp_q.delete(i);
      end
    end
    @(negedge clk);
    last_fire = bus.mul_i_valid && bus.mul_o_ready;
    if (last_fire && !(bus.mispredict && bus.flush_mask[bus.mul_i_rob_idx])) begin
      exp_q.push_back('{rob: bus.mul_i_rob_idx, rd: bus.mul_i_rd, data: pend_data, cyc: cyc});
    end
  endtask

  task automatic rest();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic step();
    half();
    rest();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int sent;
    int stall_left;
    int base;
    int waited;
    rst          = 1'b1;
    bus.wb_ready = 1'b1;
    bus.funct3   = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.mul_i_rob_idx = '0;
    bus.mul_i_rd = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 64'(bus.mul_o_valid), 64'(0));
    check("rst_rob", 64'(bus.mul_o_rob_idx), 64'(0));
    check("rst_rd", 64'(bus.mul_o_rd), 64'(0));
    check("rst_data", 64'(bus.mul_o_data), 64'(0));
    check("rst_ready", 64'(bus.mul_o_ready), 64'(1));
    @(posedge clk);
    #1;

    // Directed arithmetic with known answers, back-to-back, latency checked
    lat_chk = 1'b1;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 4'd3, 7'd9);          pend_data = 32'hFFFF_FFEB; step();
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 4'd4, 7'd10); pend_data = 32'h4000_0000; step();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 7'd11); pend_data = 32'hFFFF_FFFE; step();
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 7'd12); pend_data = 32'hFFFF_FFFF; step();
    issue(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 4'd7, 7'd13); pend_data = 32'h0;         step();
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 4'd8, 7'd14);         pend_data = 32'hFFFF_FFFF; step();
    repeat (STAGES + 2) step();
    check("dir_drain", 64'(exp_q.size()), 64'(0));

    // Eight back-to-back ops; writeback stalls 4 cycles once the first result shows
    lat_chk    = 1'b0;
    sent       = 0;
    stall_left = -1;
    base       = n_retired;
    for (int c = 0; c < 60 && (sent < 8 || exp_q.size() > 0); c++) begin
      if (sent < 8) issue(3'($urandom_range(0, 3)), $urandom, $urandom, 4'(sent), 7'(sent + 16));
      if (stall_left == -1 && bus.mul_o_valid) stall_left = 4;
      bus.wb_ready = !(stall_left > 0);
      half();
      if (stall_left > 0) begin
        check("bp_ready_low", 64'(bus.mul_o_ready), 64'(0));
        check("bp_valid_held", 64'(bus.mul_o_valid), 64'(1));
        stall_left--;
      end
      rest();
      if (last_fire) sent++;
    end
    bus.wb_ready = 1'b1;
    check("bp_retired", 64'(n_retired - base), 64'(8));
    check("bp_drain", 64'(exp_q.size()), 64'(0));

    // Three in flight, squash rob 2; a flagged issue in the same cycle is dropped
    lat_chk = 1'b1;
    base    = n_retired;
    issue(3'd0, 32'd11, 32'd13, 4'd1, 7'd21); step();
    issue(3'd0, 32'd17, 32'd19, 4'd2, 7'd22); step();
    issue(3'd0, 32'd23, 32'd29, 4'd3, 7'd23); step();
    issue(3'd0, 32'd31, 32'd37, 4'd4, 7'd24);
    bus.mispredict = 1'b1;
    bus.flush_mask = 16'h0014;
    step();
    repeat (STAGES + 3) step();
    check("sq_retired", 64'(n_retired - base), 64'(2));
    check("sq_drain", 64'(exp_q.size()), 64'(0));

    // Stalled output squashed: valid drops at once and the pipe advances
    lat_chk      = 1'b0;
    base         = n_retired;
    bus.wb_ready = 1'b0;
    issue(3'd0, 32'd5, 32'd6, 4'd5, 7'd30);
    step();
    waited = 0;
    while (!bus.mul_o_valid && waited < 20) begin
      step();
      waited++;
    end
    check("st_appeared", 64'(bus.mul_o_valid), 64'(1));
    repeat (2) step();
    issue(3'd0, 32'd8, 32'd9, 4'd6, 7'd31);
    bus.mispredict = 1'b1;
    bus.flush_mask = 16'h0020;
    half();
    check("st_sq_valid", 64'(bus.mul_o_valid), 64'(0));
    check("st_sq_ready", 64'(bus.mul_o_ready), 64'(1));
    check("st_sq_fire", 64'(last_fire), 64'(1));
    rest();
    half();
    check("st_sq_next", 64'(bus.mul_o_valid), 64'(0));
    rest();
    bus.wb_ready = 1'b1;
    repeat (STAGES + 3) step();
    check("st_retired", 64'(n_retired - base), 64'(1));
    check("st_drain", 64'(exp_q.size()), 64'(0));

    // Randomized traffic with back-pressure and sparse squashes
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 7) begin
        issue(($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
              $urandom, $urandom, 4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)));
      end
      bus.wb_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        bus.mispredict = 1'b1;
        bus.flush_mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      end
      step();
    end
    bus.wb_ready = 1'b1;
    repeat (STAGES + 20) step();
    check("rnd_drain", 64'(exp_q.size()), 64'(0));

    // Reset with two ops in flight: nothing comes out afterwards
    issue(3'd0, 32'd3, 32'd4, 4'd7, 7'd40); step();
    issue(3'd0, 32'd5, 32'd6, 4'd8, 7'd41); step();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst  = 1'b0;
    base = n_retired;
    half();
    check("mid_rst_ready", 64'(bus.mul_o_ready), 64'(1));
    check("mid_rst_valid", 64'(bus.mul_o_valid), 64'(0));
    rest();
    for (int c = 0; c < STAGES + 3; c++) begin
      half();
      check("mid_rst_quiet", 64'(bus.mul_o_valid), 64'(0));
      rest();
    end
    check("mid_rst_retired", 64'(n_retired - base), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
